// File: rtl/line_mem_responder_if.sv
// Line refill/write-back bus between a cache (master) and the line memory responder (slave).
interface line_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         protocol_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, busy, protocol_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, busy, protocol_err
  );
endinterface

// File: rtl/line_mem_responder.sv
// Slow line memory model: answers each held read/write request after LATENCY edges with a
// one-cycle ready pulse, then ignores requests for HOLDOFF cycles.
module line_mem_responder #(
  parameter int LATENCY = 8,
  parameter int HOLDOFF = 2,
  parameter int ADDR_W  = 8
) (
  input logic                clk,
  input logic                proc_reset,
  line_mem_responder_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (LATENCY > HOLDOFF) ? LATENCY : HOLDOFF;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [27:0]        addr_q;
  logic               rd_q;
  logic               wr_q;
  logic [127:0]       wdata_q;
  logic [127:0]       rdata_q;
  logic               ready_q;
  logic               busy_q;
  logic               err_q;
  logic [127:0]       mem_q [DEPTH];

  logic               req_d;
  logic               go_ready_d;
  logic               commit_wr_d;
  logic [ADDR_W-1:0]  commit_idx_d;
  logic [127:0]       commit_wdata_d;
  logic               req_changed_d;

  assign req_d         = bus.mem_read | bus.mem_write;
  assign req_changed_d = (bus.mem_addr != addr_q) | (bus.mem_read != rd_q) | (bus.mem_write != wr_q);

  // Decide whether this edge completes a request, and which line/data it commits.
  always_comb begin
    go_ready_d     = 1'b0;
    commit_wr_d    = 1'b0;
    commit_idx_d   = addr_q[ADDR_W-1:0];
    commit_wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if ((LATENCY == 1) && req_d) begin
          go_ready_d     = 1'b1;
          commit_wr_d    = bus.mem_write;
          commit_idx_d   = bus.mem_addr[ADDR_W-1:0];
          commit_wdata_d = bus.mem_wdata;
        end else begin
          go_ready_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (req_d && (cnt_q == '0)) begin
          go_ready_d  = 1'b1;
          commit_wr_d = wr_q;
        end else begin
          go_ready_d = 1'b0;
        end
      end
      default: begin
        go_ready_d = 1'b0;
      end
    endcase
  end

  // Line storage is never reset; an asserted reset blocks a commit on the same edge.
  always_ff @(posedge clk) begin
    if (go_ready_d && commit_wr_d && !proc_reset) begin
      mem_q[commit_idx_d] <= commit_wdata_d;
    end
  end

  // Request FSM with registered ready/busy/rdata/error outputs.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 28'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 128'd0;
      rdata_q <= 128'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (go_ready_d && !commit_wr_d) begin
        rdata_q <= mem_q[commit_idx_d];
      end
      case (state_q)
        ST_IDLE: begin
          if (req_d) begin
            addr_q  <= bus.mem_addr;
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            wdata_q <= bus.mem_wdata;
            busy_q  <= 1'b1;
            if (bus.mem_read && bus.mem_write) begin
              err_q <= 1'b1;
            end
            if (go_ready_d) begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= LAT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          // A dropped request is an abort, not an error.
          if (!req_d) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            if (req_changed_d) begin
              err_q <= 1'b1;
            end
            if (go_ready_d) begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        ST_READY: begin
          busy_q <= 1'b0;
          if (HOLDOFF == 0) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rdata    = rdata_q;
  assign bus.mem_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=4, HOLDOFF=2, ADDR_W=8): vector table of
// complete transactions plus hand sequences for abort, reset-mid-busy and protocol errors.
module tb_line_mem_responder;
  localparam int LAT = 4;
  localparam logic [127:0] L5   = 128'h0123_4567_89AB_CDEF_0000_1111_2222_3333;
  localparam logic [127:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] AAS  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;

  logic clk;
  logic proc_reset;
  line_mem_responder_if bus ();

  line_mem_responder #(.LATENCY(LAT), .HOLDOFF(2), .ADDR_W(8)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs [7];
  int   n_vec;
  int   n_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold a request until the pulse, keep holding through HOLD, then release.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] wd,
                         input int chg_at, input logic [27:0] a2,
                         input logic [127:0] exp_rd, input logic exp_err);
    int   k;
    logic busy_bad;
    logic second;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    tick();
    k = 0;
    busy_bad = 1'b0;
    while (!bus.mem_ready && k < 40) begin
      if (!bus.busy) busy_bad = 1'b1;
      if (k == chg_at) bus.mem_addr = a2;
      tick();
      k++;
    end
    chk({tag, " latency"}, 128'(k), 128'(LAT));
    chk({tag, " busy"}, {127'd0, busy_bad | ~bus.busy}, 128'd0);
    chk({tag, " rdata"}, bus.mem_rdata, exp_rd);
    second = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      second = second | bus.mem_ready;
      if (j == 1) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
    end
    chk({tag, " second_pulse"}, {127'd0, second}, 128'd0);
    chk({tag, " protocol_err"}, {127'd0, bus.protocol_err}, {127'd0, exp_err});
  endtask

  task automatic pulse_reset();
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    tick();
  endtask

  initial begin
    logic seen;
    n_vec = 0;
    n_bad = 0;
    vecs[0] = '{1'b0, 1'b1, 28'h0000005, L5,   128'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 28'h0000005, 128'd0, L5,   1'b0};
    vecs[2] = '{1'b0, 1'b1, 28'h0000010, DEAD, L5,     1'b0};
    vecs[3] = '{1'b1, 1'b0, 28'h0000010, 128'd0, DEAD, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 28'h0000101, AAS,  DEAD,   1'b0};
    vecs[5] = '{1'b1, 1'b0, 28'h0000001, 128'd0, AAS,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 28'h0000101, 128'd0, AAS,  1'b0};

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 28'd0;
    bus.mem_wdata = 128'd0;
    proc_reset    = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
    tick();
    chk("reset mem_ready", {127'd0, bus.mem_ready}, 128'd0);
    chk("reset busy", {127'd0, bus.busy}, 128'd0);
    chk("reset mem_rdata", bus.mem_rdata, 128'd0);
    chk("reset protocol_err", {127'd0, bus.protocol_err}, 128'd0);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              -1, 28'd0, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Abort: write held for two edges then dropped.
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h0000010;
    bus.mem_wdata = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    tick();
    tick();
    bus.mem_write = 1'b0;
    tick();
    chk("abort busy", {127'd0, bus.busy}, 128'd0);
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      seen = seen | bus.mem_ready;
      tick();
    end
    chk("abort no_ready", {127'd0, seen}, 128'd0);
    chk("abort protocol_err", {127'd0, bus.protocol_err}, 128'd0);
    run_txn("abort_readback", 1'b1, 1'b0, 28'h0000010, 128'd0, -1, 28'd0, DEAD, 1'b0);

    // Reset two edges into a write: outputs clear at once, write is lost.
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h0000005;
    bus.mem_wdata = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    tick();
    tick();
    tick();
    proc_reset    = 1'b1;
    bus.mem_write = 1'b0;
    #1;
    chk("rst_mid mem_ready", {127'd0, bus.mem_ready}, 128'd0);
    chk("rst_mid busy", {127'd0, bus.busy}, 128'd0);
    chk("rst_mid mem_rdata", bus.mem_rdata, 128'd0);
    tick();
    proc_reset = 1'b0;
    tick();
    run_txn("rst_mid_readback", 1'b1, 1'b0, 28'h0000005, 128'd0, -1, 28'd0, L5, 1'b0);

    // Address changed mid-BUSY: original address is written, error becomes sticky.
    run_txn("chg_pre", 1'b0, 1'b1, 28'h0000021, {4{32'h1212_1212}}, -1, 28'd0, L5, 1'b0);
    run_txn("chg", 1'b0, 1'b1, 28'h0000020, {4{32'h7777_7777}}, 2, 28'h0000021, L5, 1'b1);
    run_txn("chg_rd21", 1'b1, 1'b0, 28'h0000021, 128'd0, -1, 28'd0, {4{32'h1212_1212}}, 1'b1);
    run_txn("chg_rd20", 1'b1, 1'b0, 28'h0000020, 128'd0, -1, 28'd0, {4{32'h7777_7777}}, 1'b1);
    pulse_reset();
    chk("err_cleared1", {127'd0, bus.protocol_err}, 128'd0);

    // Read and write together: write wins, read data register untouched.
    run_txn("both", 1'b1, 1'b1, 28'h0000003, {4{32'h3333_3333}}, -1, 28'd0, 128'd0, 1'b1);
    run_txn("both_rd", 1'b1, 1'b0, 28'h0000003, 128'd0, -1, 28'd0, {4{32'h3333_3333}}, 1'b1);
    pulse_reset();
    chk("err_cleared2", {127'd0, bus.protocol_err}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the cache line-refill/write-back interface (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready).
- Holds DEPTH 128-bit lines and answers each request after a configurable latency with a one-cycle mem_ready pulse.
- Serves as the slow_memI/slow_memD model behind the I- and D-caches. Tolerates the requester seeing mem_ready one cycle late through its input flop.

Parameters:
LATENCY, 8, request-sample-to-ready delay in clock edges; minimum 1.
HOLDOFF, 2, cycles after the ready pulse during which requests are ignored.
ADDR_W, 8, line-index bits; DEPTH = 2**ADDR_W lines.

Ports:
clk  input  1  clock; all state updates on the rising edge.
proc_reset  input  1  asynchronous, active-high reset.
mem_read  input  1  line read request; held until ready is seen.
mem_write  input  1  line write request; held until ready is seen.
mem_addr  input  28  line address [31:4]; index = mem_addr[ADDR_W+3:4]; upper bits ignored, so addresses alias.
mem_wdata  input  128  write line data.
mem_rdata  output  128  read line data; registered.
mem_ready  output  1  one-cycle completion pulse.
busy  output  1  high in BUSY and READY states.
protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, counter=0, mem_ready=0, mem_rdata=0, busy=0, protocol_err=0. Line contents are not cleared.
- States: IDLE, BUSY, READY, HOLD.
- IDLE:
  - On an edge where (mem_read|mem_write)=1, latch addr, op, and wdata.
  - Load counter=LATENCY-1 and go to BUSY.
  - If LATENCY=1, go directly to READY.
- BUSY:
  - Decrement the counter each edge.
  - At counter=0 with the request still asserted, go to READY.
  - On the edge that moves to READY, register mem_rdata = line[idx] (read) and commit line[idx] = latched wdata (write).
  - Result: mem_ready is high exactly during the cycle following edge E0+LATENCY, where E0 is the sampling edge.
- READY:
  - mem_ready=1 for this one cycle.
  - Next edge goes to HOLD with counter=HOLDOFF-1, or to IDLE if HOLDOFF=0.
- HOLD:
  - Requests are ignored; this absorbs the requester's late ready visibility.
  - Decrement the counter; at 0, go to IDLE.
- mem_rdata holds its last read value except on the read-commit edge. Writes never change it.
- Both mem_read and mem_write high when sampled in IDLE:
  - The write is performed and the read is dropped.
  - protocol_err is set.
- Address or op change during BUSY: the latched request completes unchanged and protocol_err is set.
- Request deasserted during BUSY (abort):
  - Go to IDLE on that edge with no commit and no ready pulse. protocol_err is not set.
- Requests in HOLD or READY are ignored with no error. The requester must keep asserting; the request is re-sampled in IDLE.
- Read of a line written earlier returns the written data. A read after a write to an aliasing address returns the aliased line.
- Reset asserted mid-BUSY: return to IDLE at once with no pulse. An uncommitted write is lost.

Test Plan:
- Read latency (LATENCY=4, HOLDOFF=2): preload line 0x05=0x0123_4567_89AB_CDEF_0000_1111_2222_3333. Raise mem_read with addr 0x0000005 at E0 -> mem_ready=1 only in the cycle after E0+4 with that rdata; busy=1 from E0 until the pulse; no second pulse while mem_read is held 2 more cycles.
- Write then read: write 0xDEAD_BEEF repeated to addr 0x0000010, then read the same addr -> rdata=0xDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF; mem_rdata unchanged during the write's ready cycle.
- Aliasing (ADDR_W=8): write 0xAA..AA to addr 0x0000101 -> read of addr 0x0000001 returns 0xAA..AA.
- Abort: assert mem_write for 2 cycles then drop (LATENCY=8) -> no mem_ready; line unchanged; protocol_err=0; FSM in IDLE.
- Errors: mem_read and mem_write together at 0x0000003 -> write committed, protocol_err=1. Change mem_addr mid-BUSY on a separate request -> completes at the original address; protocol_err stays 1 until proc_reset.
- Reset mid-BUSY: proc_reset pulses at E0+2 of a write -> mem_ready, busy, and mem_rdata are 0 immediately; a later read shows the old line contents.
